// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared definitions for the counter sweep controller: counter width and the
// controller state encoding.
package counter_sweep_ctrl_pkg;

    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RAMP  = 3'd2,
        ST_UP    = 3'd3,
        ST_DOWN  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/counter_5b.sv
// 5-bit up/down counter. Its clear is synchronous and, like counting, only
// takes effect while enable is high.
module counter_5b
    import counter_sweep_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock) begin
        if (enable) begin
            if (reset) begin
                count <= '0;
            end else if (up_down) begin
                count <= count + CNT_W'(1);
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweep controller: ramps counter_5b to the low bound, then bounces it between
// the latched bounds for a programmed number of low->high->low sweeps.
module counter_sweep_ctrl
    import counter_sweep_ctrl_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] low_limit,
    input  logic [CNT_W-1:0] high_limit,
    input  logic [3:0]       num_sweeps,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam logic [3:0] PRESC_LAST = 4'(DIV - 1);

    state_t           state;
    logic [3:0]       presc;
    logic [3:0]       sweeps_done;
    logic [3:0]       sweeps_next;
    logic [CNT_W-1:0] lo_q;
    logic [CNT_W-1:0] hi_q;
    logic [3:0]       num_q;
    logic [CNT_W-1:0] next_up;
    logic [CNT_W-1:0] next_dn;
    logic             tick;
    logic             cnt_en;
    logic             cnt_clr;
    logic             cnt_up;

    assign next_up     = count + CNT_W'(1);
    assign next_dn     = count - CNT_W'(1);
    assign sweeps_next = sweeps_done + 4'd1;
    assign tick        = (presc == PRESC_LAST);

    // Counter controls follow the state that is being left on this edge, so a
    // limit-reaching step and the direction change share the same edge.
    always_comb begin
        cnt_en = 1'b0;
        case (state)
            ST_CLEAR, ST_RAMP: cnt_en = 1'b1;
            ST_UP, ST_DOWN:    cnt_en = tick;
            default:           cnt_en = 1'b0;
        endcase
        if (stop) begin
            cnt_en = 1'b0;
        end
        if (reset) begin
            cnt_en = 1'b1;
        end
        cnt_clr = reset || (state == ST_CLEAR);
        cnt_up  = (state != ST_DOWN);
    end

    counter_5b u_counter (
        .clock   (clock),
        .reset   (cnt_clr),
        .enable  (cnt_en),
        .up_down (cnt_up),
        .count   (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            presc       <= '0;
            sweeps_done <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (stop && (state != ST_IDLE)) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !stop) begin
                            if (low_limit < high_limit) begin
                                lo_q        <= low_limit;
                                hi_q        <= high_limit;
                                num_q       <= num_sweeps;
                                sweeps_done <= '0;
                                busy        <= 1'b1;
                                state       <= ST_CLEAR;
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                    ST_CLEAR: begin
                        presc <= '0;
                        state <= (lo_q == '0) ? ST_UP : ST_RAMP;
                    end
                    ST_RAMP: begin
                        presc <= '0;
                        if (next_up == lo_q) begin
                            state <= ST_UP;
                        end
                    end
                    ST_UP: begin
                        if (tick) begin
                            presc <= '0;
                            if (next_up == hi_q) begin
                                state <= ST_DOWN;
                            end
                        end else begin
                            presc <= presc + 4'd1;
                        end
                    end
                    ST_DOWN: begin
                        if (tick) begin
                            presc <= '0;
                            if (next_dn == lo_q) begin
                                sweeps_done <= sweeps_next;
                                // A zero sweep count never matches, so the run bounces until stopped.
                                if ((num_q != '0) && (sweeps_next == num_q)) begin
                                    state <= ST_DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state <= ST_UP;
                                end
                            end
                        end else begin
                            presc <= presc + 4'd1;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Scoreboard bench: three controllers (DIV 1, 2, 4) share one stimulus stream;
// expected outputs come from a triangle-wave timing model of a sweep run.
module tb_counter_sweep_ctrl;

    typedef struct {
        logic [4:0] count;
        logic       busy;
        logic       done;
        logic       error;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       start;
    logic       stop;
    logic [4:0] low_limit;
    logic [4:0] high_limit;
    logic [3:0] num_sweeps;

    logic [4:0] count1, count2, count4;
    logic       busy1, busy2, busy4;
    logic       done1, done2, done4;
    logic       error1, error2, error4;

    counter_sweep_ctrl #(.DIV(1)) u_div1 (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .low_limit(low_limit), .high_limit(high_limit), .num_sweeps(num_sweeps),
        .count(count1), .busy(busy1), .done(done1), .error(error1)
    );
    counter_sweep_ctrl #(.DIV(2)) u_div2 (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .low_limit(low_limit), .high_limit(high_limit), .num_sweeps(num_sweeps),
        .count(count2), .busy(busy2), .done(done2), .error(error2)
    );
    counter_sweep_ctrl #(.DIV(4)) u_div4 (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .low_limit(low_limit), .high_limit(high_limit), .num_sweeps(num_sweeps),
        .count(count4), .busy(busy4), .done(done4), .error(error4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   passed = 0;

    // Model state per instance: a run is described by its accept edge and its
    // latched bounds; everything else is derived arithmetically from elapsed edges.
    bit run_m[3];
    int ts_m[3];
    int lo_m[3];
    int hi_m[3];
    int num_m[3];
    int cnt_m[3];
    int now = 0;

    function automatic int div_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    // Edge (relative to accept) on which the final step lands on the low bound.
    function automatic int done_time(input int k);
        int span;
        span = hi_m[k] - lo_m[k];
        if (num_m[k] == 0) return 1 << 30;
        return lo_m[k] + 1 + 2 * span * num_m[k] * div_of(k);
    endfunction

    // Count after edge t of a run: clear, ramp one per edge, then a triangle
    // wave between the bounds advancing one step per DIV edges.
    function automatic int sweep_count(input int k, input int t);
        int t0, span, j, p;
        t0 = lo_m[k] + 1;
        if (t <= t0) return t - 1;
        span = hi_m[k] - lo_m[k];
        j = (t - t0) / div_of(k);
        p = j % (2 * span);
        return lo_m[k] + ((p <= span) ? p : (2 * span - p));
    endfunction

    task automatic predict(input int k, input bit r, input bit st, input bit sp,
                           input int lo, input int hi, input int num, output exp_t e);
        int t, td;
        e.done  = 1'b0;
        e.error = 1'b0;
        e.busy  = 1'b0;
        if (r) begin
            run_m[k] = 1'b0;
            cnt_m[k] = 0;
        end else begin
            t  = now - ts_m[k];
            td = done_time(k);
            if (run_m[k] && (t > td)) begin
                run_m[k] = 1'b0;
            end else if (run_m[k]) begin
                if (sp) begin
                    run_m[k] = 1'b0;
                end else begin
                    cnt_m[k] = sweep_count(k, t);
                    e.busy   = 1'b1;
                    e.done   = (t == td);
                end
            end else if (st && !sp) begin
                if (lo < hi) begin
                    run_m[k] = 1'b1;
                    ts_m[k]  = now;
                    lo_m[k]  = lo;
                    hi_m[k]  = hi;
                    num_m[k] = num;
                    e.busy   = 1'b1;
                end else begin
                    e.error = 1'b1;
                end
            end
        end
        e.count = 5'(cnt_m[k]);
    endtask

    task automatic drive(input bit r, input bit st, input bit sp,
                         input int lo, input int hi, input int num);
        exp_t e;
        reset      = r;
        start      = st;
        stop       = sp;
        low_limit  = 5'(lo);
        high_limit = 5'(hi);
        num_sweeps = 4'(num);
        for (int k = 0; k < 3; k++) begin
            predict(k, r, st, sp, lo, hi, num, e);
            case (k)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        now++;
        @(posedge clock);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b0, $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 15));
        end
    endtask

    task automatic check(input exp_t e, input logic [4:0] c, input logic b,
                         input logic d, input logic er, input string nm);
        checks++;
        if ({c, b, d, er} === {e.count, e.busy, e.done, e.error}) begin
            passed++;
        end else begin
            $display("FAIL %s @%0t: count=%0d busy=%b done=%b error=%b, expected count=%0d busy=%b done=%b error=%b",
                     nm, $time, c, b, d, er, e.count, e.busy, e.done, e.error);
        end
    endtask

    // Monitor: one sample per edge, taken 1 time unit after it.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (q0.size() > 0) check(q0.pop_front(), count1, busy1, done1, error1, "div1");
            if (q1.size() > 0) check(q1.pop_front(), count2, busy2, done2, error2, "div2");
            if (q2.size() > 0) check(q2.pop_front(), count4, busy4, done4, error4, "div4");
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, hi;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
        idle(2);

        // lo=2 hi=5, one sweep
        drive(1'b0, 1'b1, 1'b0, 2, 5, 1);
        idle(35);

        // lo=0 skips the ramp; a start with new limits arrives mid-run
        drive(1'b0, 1'b1, 1'b0, 0, 3, 2);
        idle(7);
        drive(1'b0, 1'b1, 1'b0, 10, 20, 5);
        idle(50);

        // rejected starts: equal and inverted bounds
        drive(1'b0, 1'b1, 1'b0, 7, 7, 1);
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 9, 4, 1);
        idle(2);

        // endless bouncing, then stop when the DIV=2 instance shows 2
        drive(1'b0, 1'b1, 1'b0, 1, 3, 0);
        idle(45);
        for (int i = 0; i < 20 && cnt_m[1] != 2; i++) idle(1);
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0);
        idle(3);

        // reset together with stop and start while the DIV=4 run is descending
        drive(1'b0, 1'b1, 1'b0, 0, 5, 0);
        idle(26);
        drive(1'b1, 1'b1, 1'b1, 0, 5, 0);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            lo = $urandom_range(0, 20);
            hi = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lo) : lo + $urandom_range(1, 6);
            drive(($urandom_range(0, 149) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 39) == 0), lo, hi, $urandom_range(0, 3));
        end
        idle(2);

        checks++;
        if (q0.size() + q1.size() + q2.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL drain: %0d samples left unchecked, expected 0",
                     q0.size() + q1.size() + q2.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
